// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared serial-link package: FSM states, link codes, baud divisor
package serial_pkg;

  // Receiver FSM states. The ST_ prefix keeps them apart from the START link code.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  // Handshake codes exchanged by connect and the benches
  localparam logic [7:0] RDY       = 8'h90;
  localparam logic [7:0] RDY_ACK   = 8'h91;
  localparam logic [7:0] START     = 8'h92;
  localparam logic [7:0] START_ACK = 8'h93;

  // Clocks per oversample tick, truncating
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    return clk_hz / (baud * os);
  endfunction

endpackage

// File: rtl/serial_baud_tick.sv
// rtl/serial_baud_tick.sv - oversample tick divider with synchronous restart
module serial_baud_tick #(
  parameter int unsigned DIV = 54
) (
  input  logic clk,
  input  logic reset,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Next count: restart wins, otherwise wrap at DIV-1 and flag a tick
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    tick_d = 1'b0;
    if (restart_i) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DIV - 1)) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  // Counter and registered tick pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - oversampling UART receiver; SERIAL_RX_PARITY_EN adds even parity
module serial_rx
  import serial_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned OVERSAMPLE  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] DataOut,
  output logic       DataRdy,
  output logic       FrameErr,
  output logic       ParityErr,
  output logic       Busy
);

  localparam int unsigned   DIV      = calc_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned   SW       = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] IDX_LO   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] IDX_MID  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] IDX_HI   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] IDX_LAST = SW'(OVERSAMPLE - 1);

  rx_state_e     state_q;
  logic [1:0]    sync_q;
  logic          prev_q;
  logic [1:0]    settle_q;
  logic [SW-1:0] samp_q, samp_d;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q, data_q;
  logic          s_lo_q, s_mid_q;
  logic          rdy_q, ferr_q, busy_q;
  logic          line, fall, start_det, tick, bit_val;
`ifdef SERIAL_RX_PARITY_EN
  logic          perr_q, par_bad_q;
`endif

  // Synchroniser plus history flop; settle_q hides the reset value of the
  // synchroniser so a line held low through reset is never taken as a start edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q   <= 2'b11;
      prev_q   <= 1'b1;
      settle_q <= 2'd0;
    end else begin
      sync_q <= {sync_q[0], rx};
      prev_q <= sync_q[1];
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
    end
  end

  assign line      = sync_q[1];
  assign fall      = (settle_q == 2'd3) && prev_q && !line;
  assign start_det = (state_q == ST_IDLE) && fall;
  assign samp_d    = (samp_q == IDX_LAST) ? '0 : samp_q + 1'b1;
  assign bit_val   = (s_lo_q & s_mid_q) | (s_lo_q & line) | (s_mid_q & line);

  serial_baud_tick #(.DIV(DIV)) u_tick (
    .clk       (clk),
    .reset     (reset),
    .restart_i (start_det),
    .tick_o    (tick)
  );

  // Frame FSM: decisions at the third centred sample of each bit, registered strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      samp_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      s_lo_q  <= 1'b0;
      s_mid_q <= 1'b0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      rdy_q  <= 1'b0;
      ferr_q <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      perr_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (start_det) begin
            state_q <= ST_START;
            busy_q  <= 1'b1;
            samp_q  <= '0;
            bit_q   <= 3'd0;
          end
        end
        ST_BREAK: begin
          if (line) state_q <= ST_IDLE;
        end
        default: begin
          if (tick) begin
            samp_q <= samp_d;
            if (samp_d == IDX_LO)  s_lo_q  <= line;
            if (samp_d == IDX_MID) s_mid_q <= line;
            if (samp_d == IDX_HI) begin
              case (state_q)
                ST_START: begin
                  if (bit_val) begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                  end else begin
                    state_q <= ST_DATA;
                  end
                end
                ST_DATA: begin
                  shift_q <= {bit_val, shift_q[7:1]};
                  bit_q   <= bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                    state_q <= ST_PARITY;
`else
                    state_q <= ST_STOP;
`endif
                  end
                end
`ifdef SERIAL_RX_PARITY_EN
                ST_PARITY: begin
                  par_bad_q <= bit_val ^ (^shift_q);
                  state_q   <= ST_STOP;
                end
`endif
                ST_STOP: begin
                  busy_q  <= 1'b0;
                  state_q <= bit_val ? ST_IDLE : ST_BREAK;
`ifdef SERIAL_RX_PARITY_EN
                  if (par_bad_q) begin
                    perr_q <= 1'b1;
                  end else
`endif
                  if (!bit_val) begin
                    ferr_q <= 1'b1;
                  end else begin
                    data_q <= shift_q;
                    rdy_q  <= 1'b1;
                  end
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign DataOut  = data_q;
  assign DataRdy  = rdy_q;
  assign FrameErr = ferr_q;
  assign Busy     = busy_q;
`ifdef SERIAL_RX_PARITY_EN
  assign ParityErr = perr_q;
`else
  assign ParityErr = 1'b0;
`endif

endmodule

// File: tb/tb_serial_rx.sv
// tb/tb_serial_rx.sv - self-checking bench for serial_rx against a frame-level model
`timescale 1ns/1ps
module tb_serial_rx;

  localparam int unsigned CLK_HZ = 20_000_000;
  localparam int unsigned BAUD   = 115200;
  localparam int unsigned OS     = 16;
  localparam int DIV      = CLK_HZ / (BAUD * OS);
`ifdef SERIAL_RX_PARITY_EN
  localparam bit PAR_EN   = 1'b1;
  localparam int STOP_BIT = 10;
`else
  localparam bit PAR_EN   = 1'b0;
  localparam int STOP_BIT = 9;
`endif
  localparam int LAT      = 4 + (STOP_BIT * OS + OS / 2 + 1) * DIV;
  localparam int FALSE_T  = 4 + (OS / 2 + 1) * DIV;
  localparam int BIT_P    = OS * DIV;
  localparam int BIT_FAST = BIT_P * 98 / 100;

  localparam int K_OK = 0, K_FERR = 1, K_PERR = 2, K_FALSE = 3;

  typedef struct {
    int         start;
    int         endc;
    int         kind;
    logic [7:0] data;
  } rec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] DataOut;
  logic       DataRdy, FrameErr, ParityErr, Busy;

  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  rec_t       q[$];
  int         idx = 0;
  logic [7:0] exp_dout = 8'h00;
  int         rdy_cyc[$];
  logic [7:0] rdy_dat[$];
  int         ferr_cnt = 0;
  int         perr_cnt = 0;
  int         first_start = 0;

  serial_rx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .DataOut   (DataOut),
    .DataRdy   (DataRdy),
    .FrameErr  (FrameErr),
    .ParityErr (ParityErr),
    .Busy      (Busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int outcome(input logic stop_b, input logic bad_par);
    if (PAR_EN && bad_par) return K_PERR;
    if (!stop_b) return K_FERR;
    return K_OK;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one frame from "#1 after posedge"; cut > 0 aborts after that many clocks
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic bad_par,
                            input int bitp, input int cut);
    logic b[$];
    int   el;
    rec_t r;
    b.push_back(1'b0);
    for (int i = 0; i < 8; i++) b.push_back(d[i]);
    if (PAR_EN) b.push_back((^d) ^ bad_par);
    b.push_back(stop_b);
    r.start = cyc;
    r.endc  = cyc + LAT;
    r.kind  = outcome(stop_b, bad_par);
    r.data  = d;
    q.push_back(r);
    el = 0;
    foreach (b[i]) begin
      rx = b[i];
      for (int j = 0; j < bitp; j++) begin
        @(posedge clk);
        #1;
        el++;
        if (cut > 0 && el >= cut) return;
      end
    end
  endtask

  task automatic glitch(input int ticks);
    rec_t r;
    r.start = cyc;
    r.endc  = cyc + FALSE_T;
    r.kind  = K_FALSE;
    r.data  = 8'h00;
    q.push_back(r);
    rx = 1'b0;
    idle(ticks * DIV);
    rx = 1'b1;
  endtask

  // Per-cycle comparison of every output against the frame-level model
  always @(negedge clk) begin
    logic e_rdy, e_ferr, e_perr, e_busy;
    rec_t r;
    e_rdy = 1'b0; e_ferr = 1'b0; e_perr = 1'b0; e_busy = 1'b0;
    if (!reset) begin
      exp_dout = 8'h00;
      while (idx < q.size() && q[idx].start <= cyc) idx++;
    end else if (idx < q.size()) begin
      r = q[idx];
      if (cyc >= r.start + 3 && cyc < r.endc) e_busy = 1'b1;
      if (cyc == r.endc) begin
        case (r.kind)
          K_OK: begin e_rdy = 1'b1; exp_dout = r.data; end
          K_FERR: e_ferr = 1'b1;
          K_PERR: e_perr = 1'b1;
          default: ;
        endcase
        idx++;
      end
    end
    chk($sformatf("cycle %0d {Busy,Rdy,FErr,PErr,DataOut}", cyc),
        int'({Busy, DataRdy, FrameErr, ParityErr, DataOut}),
        int'({e_busy, e_rdy, e_ferr, e_perr, exp_dout}));
    if (reset && DataRdy) begin
      rdy_cyc.push_back(cyc);
      rdy_dat.push_back(DataOut);
    end
    if (reset && FrameErr) ferr_cnt++;
    if (reset && ParityErr) perr_cnt++;
  end

  initial begin
    idle(5);
    reset = 1'b1;
    chk("reset DataOut", int'(DataOut), 8'h00);
    chk("reset Busy", int'(Busy), 0);
    idle(50);

    // single frame, nominal rate
    first_start = cyc + 0;
    send_frame(8'h90, 1'b1, 1'b0, BIT_P, 0);
    idle(300);
    chk("first rdy count", rdy_cyc.size(), 1);
`ifdef SERIAL_RX_PARITY_EN
    if (rdy_cyc.size() > 0) chk("first latency", rdy_cyc[0] - first_start, 1694);
`else
    if (rdy_cyc.size() > 0) chk("first latency", rdy_cyc[0] - first_start, 1534);
`endif
    chk("first DataOut", int'(DataOut), 8'h90);

    // back-to-back, transmitter fast
    send_frame(8'h91, 1'b1, 1'b0, BIT_FAST, 0);
    send_frame(8'h92, 1'b1, 1'b0, BIT_FAST, 0);
    send_frame(8'h93, 1'b1, 1'b0, BIT_FAST, 0);
    idle(300);
    chk("b2b rdy count", rdy_cyc.size(), 4);
    if (rdy_dat.size() >= 4) begin
      chk("b2b byte0", int'(rdy_dat[1]), 8'h91);
      chk("b2b byte1", int'(rdy_dat[2]), 8'h92);
      chk("b2b byte2", int'(rdy_dat[3]), 8'h93);
    end

    // short low glitch: false start
    glitch(3);
    idle(600);
    chk("glitch rdy count", rdy_cyc.size(), 4);
    chk("glitch ferr count", ferr_cnt, 0);

    // framing error then long break, then a good frame
    send_frame(8'h55, 1'b0, 1'b0, BIT_P, 0);
    idle(20 * BIT_P);
    rx = 1'b1;
    idle(300);
    chk("break ferr count", ferr_cnt, 1);
    chk("break DataOut kept", int'(DataOut), 8'h93);
    send_frame(8'h92, 1'b1, 1'b0, BIT_P, 0);
    idle(300);
    chk("after break DataOut", int'(DataOut), 8'h92);

    // reset during data bit 4 of 8'hA5, released while the line is still low
    send_frame(8'hA5, 1'b1, 1'b0, BIT_P, 5 * BIT_P + BIT_P / 2);
    reset = 1'b0;
    idle(4);
    reset = 1'b1;
    chk("mid-reset DataOut", int'(DataOut), 8'h00);
    idle(40);
    rx = 1'b1;
    idle(2 * BIT_P);
    chk("mid-reset no strobe", rdy_cyc.size(), 5);
    send_frame(8'h90, 1'b1, 1'b0, BIT_P, 0);
    idle(300);
    chk("post-reset DataOut", int'(DataOut), 8'h90);

`ifdef SERIAL_RX_PARITY_EN
    send_frame(8'h93, 1'b1, 1'b1, BIT_P, 0);
    idle(300);
    chk("bad parity perr count", perr_cnt, 1);
    chk("bad parity DataOut kept", int'(DataOut), 8'h90);
    send_frame(8'h93, 1'b1, 1'b0, BIT_P, 0);
    idle(300);
    chk("good parity DataOut", int'(DataOut), 8'h93);
    chk("total rdy count", rdy_cyc.size(), 7);
    chk("total perr count", perr_cnt, 1);
`else
    chk("total rdy count", rdy_cyc.size(), 6);
    chk("total perr count", perr_cnt, 0);
`endif
    chk("total ferr count", ferr_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
